// File: rtl/communication_tx_arbiter_n_if.sv
// Source-FIFO read side and TX-FIFO write side of the N-channel TX arbiter.
// master = arbiter, slave = FIFO environment.
interface communication_tx_arbiter_n_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 8
);
  logic [NUM_CH-1:0]        src_fifo_empty;
  logic [NUM_CH*DATA_W-1:0] src_fifo_data;
  logic [NUM_CH-1:0]        src_fifo_re;
  logic                     tx_fifo_full;
  logic                     tx_fifo_we;
  logic [TAG_W+DATA_W-1:0]  tx_fifo_data;

  modport master (
    input  src_fifo_empty, src_fifo_data, tx_fifo_full,
    output src_fifo_re, tx_fifo_we, tx_fifo_data
  );

  modport slave (
    output src_fifo_empty, src_fifo_data, tx_fifo_full,
    input  src_fifo_re, tx_fifo_we, tx_fifo_data
  );
endinterface

// File: rtl/communication_tx_arbiter_n.sv
// Drains NUM_CH source FIFOs into one TX FIFO, tagging each word with its channel.
// Round-robin or fixed-priority grants with a programmable burst length per grant.
module communication_tx_arbiter_n #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned CNT_W     = $clog2(BURST_MAX + 1),
  localparam int unsigned GNT_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arb_mode,
  input  logic [CNT_W-1:0]          burst_len,
  communication_tx_arbiter_n_if.master bus,
  output logic [GNT_W-1:0]          grant_ch,
  output logic                      busy
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

  state_t                  state;
  logic [GNT_W-1:0]        rr_ptr;
  logic [CNT_W-1:0]        burst_l;
  logic [CNT_W-1:0]        count;
  logic                    in_flight;
  logic [TAG_W+DATA_W-1:0] data_hold;

  logic                    sel_valid;
  logic [GNT_W-1:0]        sel_ch;
  logic [GNT_W-1:0]        scan_ch;
  logic [CNT_W-1:0]        len_eff;
  logic                    grant_empty;
  logic                    re_ok;
  logic [DATA_W-1:0]       src_word;
  logic [TAG_W+DATA_W-1:0] tx_word;

  // Channel selection: rotate from rr_ptr, or strict index order in priority mode.
  always_comb begin
    sel_valid = 1'b0;
    sel_ch    = '0;
    scan_ch   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      scan_ch = arb_mode ? GNT_W'(i) : GNT_W'((32'(rr_ptr) + i) % NUM_CH);
      if (!sel_valid && !bus.src_fifo_empty[scan_ch]) begin
        sel_valid = 1'b1;
        sel_ch    = scan_ch;
      end
    end
  end

  // Burst length 0 means one word; anything above BURST_MAX saturates.
  always_comb begin
    if (burst_len == '0)
      len_eff = CNT_W'(1);
    else if (32'(burst_len) > BURST_MAX)
      len_eff = CNT_W'(BURST_MAX);
    else
      len_eff = burst_len;
  end

  always_comb begin
    src_word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (GNT_W'(k) == grant_ch) src_word = bus.src_fifo_data[k*DATA_W +: DATA_W];
    end
  end

  // Read enable looks at this cycle's empty/full so it can never hit an empty source.
  always_comb begin
    grant_empty = bus.src_fifo_empty[grant_ch];
    re_ok       = (state == S_BURST) && !grant_empty && !bus.tx_fifo_full && (count < burst_l);
  end

  assign bus.src_fifo_re  = re_ok ? (NUM_CH'(1) << grant_ch) : '0;
  assign tx_word          = in_flight ? {TAG_W'(grant_ch), src_word} : data_hold;
  assign bus.tx_fifo_data = tx_word;
  assign bus.tx_fifo_we   = in_flight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_ch  <= '0;
      burst_l   <= '0;
      count     <= '0;
      in_flight <= 1'b0;
      data_hold <= '0;
      busy      <= 1'b0;
    end else begin
      in_flight <= re_ok;
      if (in_flight) data_hold <= tx_word;
      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            grant_ch <= sel_ch;
            burst_l  <= len_eff;
            count    <= '0;
            state    <= S_BURST;
            busy     <= 1'b1;
          end
        end
        S_BURST: begin
          if (re_ok) count <= count + CNT_W'(1);
          if ((re_ok && (count + CNT_W'(1) == burst_l)) || (!re_ok && grant_empty)
              || (count >= burst_l))
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Last word drains through the write path this cycle.
          rr_ptr <= (grant_ch == GNT_W'(NUM_CH - 1)) ? '0 : grant_ch + GNT_W'(1);
          state  <= S_IDLE;
          busy   <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/communication_tx_arbiter_n.md
Name: communication_tx_arbiter_n

Overview:
- Parametrised N-channel successor to the two-source TX arbiter.
- Drains NUM_CH single-clock source FIFOs into one shared TX FIFO. The TX FIFO feeds the clock-crossing FIFO toward the FT601 interface.
- Each output word is tagged with its source channel index.
- Supports round-robin or fixed-priority arbitration with programmable burst length per grant.

Parameters:
- NUM_CH, 4, number of source channels (2..16)
- DATA_W, 32, source data width
- TAG_W, 8, channel tag width in output word (TAG_W >= clog2(NUM_CH))
- BURST_MAX, 16, maximum words per grant
- CNT_W, clog2(BURST_MAX+1), burst counter width

Ports:
- Clock  in  1  system clock; all logic rising-edge
- Reset_N  in  1  asynchronous active-low reset
- Arb_Mode  in  1  0 = round-robin, 1 = fixed priority (ch0 highest)
- Burst_Len  in  CNT_W  words per grant; 0 is treated as 1, values >BURST_MAX clamp to BURST_MAX
- Src_Fifo_Empty  in  NUM_CH  per-channel empty flag
- Src_Fifo_Data  in  NUM_CH*DATA_W  flattened; channel k at [k*DATA_W +: DATA_W]
- Src_Fifo_RE  out  NUM_CH  one-hot read enable; source data valid 1 cycle after RE
- TX_Fifo_Full  in  1  TX FIFO almost-full (at least 2 free entries when deasserted)
- TX_Fifo_WE  out  1  TX write strobe
- TX_Fifo_Data  out  TAG_W+DATA_W  {tag, data}
- Grant_Ch  out  clog2(NUM_CH)  currently/last granted channel
- Busy  out  1  high in S_BURST and S_DRAIN

Behaviour:
- Reset values:
  - All outputs 0; state S_IDLE.
  - rr_ptr = 0, burst count = 0, in-flight flag = 0.
  - Reset mid-burst aborts immediately. Any in-flight word is dropped with no WE.
- S_IDLE: if any Src_Fifo_Empty bit is 0, select a channel in the same cycle and go to S_BURST next cycle.
  - Arb_Mode=0: first non-empty channel scanning rr_ptr, rr_ptr+1, ... modulo NUM_CH.
  - Arb_Mode=1: lowest-index non-empty channel.
  - On selection, latch Grant_Ch, latch effective burst length L, clear count.
  - Arb_Mode and Burst_Len are sampled only here; changes mid-burst take effect at next arbitration.
- S_BURST: Src_Fifo_RE[Grant_Ch] = 1 when all hold:
  - Src_Fifo_Empty[Grant_Ch] = 0
  - TX_Fifo_Full = 0
  - count < L
  - Each RE increments count.
- Stall: if TX_Fifo_Full=1 or the source is momentarily full-stalled, RE stays low and the state holds. The grant is kept while count<L and the source is non-empty.
- End of burst: exit to S_DRAIN when count reaches L or the granted source reports empty.
- S_DRAIN: one cycle to flush the last in-flight word.
  - rr_ptr <= (Grant_Ch+1) mod NUM_CH.
  - Return to S_IDLE, so there is one dead cycle between bursts.
- Write path, fixed 1-cycle latency: TX_Fifo_WE(t+1) = RE issued at t.
  - TX_Fifo_Data(t+1) = {zero-extended Grant_Ch, Src_Fifo_Data[Grant_Ch](t+1)}.
  - TX_Fifo_Data holds its last value when WE=0.
- Almost-full: TX_Fifo_Full asserting in the same cycle as an in-flight word still permits that word's WE. Margin is guaranteed by the 2-entry almost-full threshold.
- Never more than one RE bit high. RE is never asserted to a channel whose empty flag is 1 in that cycle.
- NUM_CH=1: arbitration degenerates. Grant_Ch is always 0; bursts still separated by S_DRAIN.

Test Plan:
- Reset with all sources non-empty, Reset_N low 5 cycles:
  - During reset: all outputs 0.
  - First RE after release is on ch0 (rr_ptr=0), reaching S_BURST 1 cycle after S_IDLE.
- Round-robin fairness: Arb_Mode=0, Burst_Len=4, ch0..ch3 each preloaded with 8 words (ch k data = 0xk000_000n):
  - Grant order 0,1,2,3,0,1,2,3; 4 WEs per grant.
  - TX data tags 0x00..0x03 match the payload channel.
  - 32 words total; exactly 1 idle cycle between bursts in addition to S_DRAIN.
- Fixed priority starvation: Arb_Mode=1, Burst_Len=2, ch0 continuously refilled, ch2 holds 3 words:
  - ch2 never granted while ch0 non-empty.
  - Stopping ch0 yields a ch2 grant within 4 cycles.
- Back-pressure: assert TX_Fifo_Full for 10 cycles mid-burst (after 3 of 8 words):
  - RE low during the stall; at most 1 WE occurs after Full rises.
  - Resume completes the remaining 5 words.
  - No word lost or duplicated (scoreboard by tag+data).
- Source runs dry: Burst_Len=16, ch1 has 3 words:
  - Burst ends after 3 WEs and goes to S_DRAIN.
  - rr_ptr=2; next grant is ch2 if non-empty.
- Boundary values:
  - Burst_Len=0 behaves as 1 word/grant.
  - Burst_Len=31 with BURST_MAX=16 behaves as 16.
  - Reset asserted mid-burst: RE and WE drop asynchronously; the in-flight word is not written.
